// File: rtl/mem_responder.sv
// Single-outstanding memory responder with byte-lane writes and a fixed response latency.
// Optional feature: define MISALIGN_CHECK_EN to reject accesses whose address is not word aligned.
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_wstrb,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [3:0]    r_cnt;
    logic [3:0]    w_nextCnt;
    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [31:0]   r_rdata;
    logic [AW-1:0] w_idx;
    logic          w_accept;
    logic          w_misalign;
    logic          w_doWrite;
    logic          w_unusedAddr;

    assign w_idx        = i_req_addr[AW+1:2];
    assign w_accept     = i_req_valid && o_req_ready;
    assign w_doWrite    = w_accept && i_req_we && !w_misalign;
    assign w_unusedAddr = ^{i_req_addr[31:AW+2], i_req_addr[1:0]};

`ifdef MISALIGN_CHECK_EN
    logic r_err;

    assign w_misalign = (i_req_addr[1:0] != 2'b00);
    assign o_resp_err = r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_misalign;
        end
    end
`else
    assign w_misalign = 1'b0;
    assign o_resp_err = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    // WAIT is held for LATENCY-1 cycles so resp_valid rises LATENCY cycles after acceptance.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (i_req_valid) begin
                    if (LATENCY > 1) begin
                        w_nextState = WAIT;
                        w_nextCnt   = CNT_INIT;
                    end else begin
                        w_nextState = RESP;
                    end
                end
            end
            WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_nextState = RESP;
                    w_nextCnt   = 4'd0;
                end else begin
                    w_nextCnt = r_cnt - 4'd1;
                end
            end
            RESP: begin
                if (i_resp_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextCnt   = 4'd0;
            end
        endcase
    end

    always_comb begin
        o_req_ready  = (r_state == IDLE);
        o_resp_valid = (r_state == RESP);
        o_resp_rdata = r_rdata;
    end

    // Read data is sampled on the acceptance edge, before any write in that edge lands.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= 32'd0;
        end else if (w_accept) begin
            r_rdata <= (i_req_we || w_misalign) ? 32'd0 : r_mem[w_idx];
        end
    end

    // Storage has no reset so committed writes survive a mid-transaction reset.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_doWrite && i_req_wstrb[b]) begin
                r_mem[w_idx][8*b +: 8] <= i_req_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: table-driven transactions plus stall, reset and alignment sequences.
// Expectations follow MISALIGN_CHECK_EN when the macro is defined for the build.
module tb_mem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          hold;
        bit          earlyReady;
        logic [31:0] expRdata;
        logic        expErr;
    } vector_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        reqValid;
    logic        reqReady;
    logic        reqWe;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic [3:0]  reqWstrb;
    logic        respValid;
    logic        respReady;
    logic [31:0] respRdata;
    logic        respErr;

    int checkCount = 0;
    int failCount  = 0;

    vector_t basicVecs[$];
    vector_t alignVecs[$];

    mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_req_valid (reqValid),
        .o_req_ready (reqReady),
        .i_req_we    (reqWe),
        .i_req_addr  (reqAddr),
        .i_req_wdata (reqWdata),
        .i_req_wstrb (reqWstrb),
        .o_resp_valid(respValid),
        .i_resp_ready(respReady),
        .o_resp_rdata(respRdata),
        .o_resp_err  (respErr)
    );

    always #5 clk = ~clk;

    function automatic vector_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [3:0] wstrb, input int hold, input bit earlyReady,
                                   input logic [31:0] expRdata, input logic expErr);
        vector_t v;
        v.we         = we;
        v.addr       = addr;
        v.wdata      = wdata;
        v.wstrb      = wstrb;
        v.hold       = hold;
        v.earlyReady = earlyReady;
        v.expRdata   = expRdata;
        v.expErr     = expErr;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vector_t v, input bit injectDuringHold);
        int waitCyc;
        int lat;
        @(negedge clk);
        waitCyc = 0;
        while (!reqReady && waitCyc < 20) begin
            @(negedge clk);
            waitCyc++;
        end
        checkOutput("req_ready before request", reqReady, 1);
        reqValid  = 1'b1;
        reqWe     = v.we;
        reqAddr   = v.addr;
        reqWdata  = v.wdata;
        reqWstrb  = v.wstrb;
        respReady = v.earlyReady;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        lat = 1;
        while (!respValid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput($sformatf("latency addr 0x%08h", v.addr), lat, LAT);
        checkOutput($sformatf("rdata addr 0x%08h", v.addr), respRdata, v.expRdata);
        checkOutput($sformatf("err addr 0x%08h", v.addr), respErr, v.expErr);
        if (!v.earlyReady) begin
            for (int i = 0; i < v.hold; i++) begin
                if (i == 0 && injectDuringHold) begin
                    reqValid = 1'b1;
                    reqWe    = 1'b1;
                    reqWdata = 32'h0;
                    reqWstrb = 4'hF;
                end
                @(negedge clk);
                checkOutput("stall resp_valid", respValid, 1);
                checkOutput("stall rdata", respRdata, v.expRdata);
                checkOutput("stall req_ready", reqReady, 0);
            end
            reqValid  = 1'b0;
            respReady = 1'b1;
        end
        @(negedge clk);
        respReady = 1'b0;
        checkOutput("resp_valid after handshake", respValid, 0);
        checkOutput("req_ready after handshake", reqReady, 1);
    endtask

    initial begin
        rstN      = 1'b0;
        reqValid  = 1'b0;
        reqWe     = 1'b0;
        reqAddr   = 32'h0;
        reqWdata  = 32'h0;
        reqWstrb  = 4'h0;
        respReady = 1'b0;

        basicVecs.push_back(mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0,         1'b0));
        basicVecs.push_back(mk(1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0));
        basicVecs.push_back(mk(1'b1, 32'h0000_0010, 32'h0000_00AA, 4'h1, 0, 1'b0, 32'h0,         1'b0));
        basicVecs.push_back(mk(1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 1'b1, 32'hDEAD_BEAA, 1'b0));
        basicVecs.push_back(mk(1'b1, 32'h0000_1004, 32'h0000_0055, 4'hF, 0, 1'b0, 32'h0,         1'b0));
        basicVecs.push_back(mk(1'b0, 32'h0000_0004, 32'h0,         4'h0, 0, 1'b0, 32'h0000_0055, 1'b0));
        basicVecs.push_back(mk(1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 0, 1'b0, 32'h0,         1'b0));
        basicVecs.push_back(mk(1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, 0, 1'b1, 32'h0,         1'b0));
        basicVecs.push_back(mk(1'b0, 32'h0000_0020, 32'h0,         4'h0, 0, 1'b0, 32'h1122_3344, 1'b0));
        basicVecs.push_back(mk(1'b1, 32'h0000_0024, 32'h0102_0304, 4'hF, 0, 1'b0, 32'h0,         1'b0));
        basicVecs.push_back(mk(1'b1, 32'h0000_0024, 32'hAABB_CCDD, 4'hA, 0, 1'b0, 32'h0,         1'b0));
        basicVecs.push_back(mk(1'b0, 32'h0000_0024, 32'h0,         4'h0, 0, 1'b0, 32'hAA02_CC04, 1'b0));
        basicVecs.push_back(mk(1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 4'hF, 0, 1'b0, 32'h0,         1'b0));
        basicVecs.push_back(mk(1'b0, 32'h0000_3FFC, 32'h0,         4'h0, 0, 1'b0, 32'hCAFE_F00D, 1'b0));

`ifdef MISALIGN_CHECK_EN
        alignVecs.push_back(mk(1'b1, 32'h0000_0012, 32'h9999_9999, 4'hF, 0, 1'b0, 32'h0,         1'b1));
        alignVecs.push_back(mk(1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 1'b0, 32'hDEAD_BEAA, 1'b0));
        alignVecs.push_back(mk(1'b0, 32'h0000_0013, 32'h0,         4'h0, 0, 1'b0, 32'h0,         1'b1));
`else
        alignVecs.push_back(mk(1'b1, 32'h0000_0012, 32'h9999_9999, 4'hF, 0, 1'b0, 32'h0,         1'b0));
        alignVecs.push_back(mk(1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 1'b0, 32'h9999_9999, 1'b0));
        alignVecs.push_back(mk(1'b0, 32'h0000_0013, 32'h0,         4'h0, 0, 1'b0, 32'h9999_9999, 1'b0));
`endif

        #2;
        checkOutput("reset req_ready", reqReady, 1);
        checkOutput("reset resp_valid", respValid, 0);
        checkOutput("reset rdata", respRdata, 32'h0);
        checkOutput("reset err", respErr, 0);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;

        foreach (basicVecs[i]) begin
            applyStimulus(basicVecs[i], 1'b0);
        end

        // Stalled read with a competing write request that must be ignored.
        applyStimulus(mk(1'b0, 32'h0000_0010, 32'h0, 4'h0, 5, 1'b0, 32'hDEAD_BEAA, 1'b0), 1'b1);
        applyStimulus(mk(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 1'b0, 32'hDEAD_BEAA, 1'b0), 1'b0);

        // Reset while a write waits for its response.
        @(negedge clk);
        reqValid = 1'b1;
        reqWe    = 1'b1;
        reqAddr  = 32'h0000_0030;
        reqWdata = 32'h0BAD_F00D;
        reqWstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        checkOutput("wait req_ready", reqReady, 0);
        checkOutput("wait resp_valid", respValid, 0);
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("mid reset req_ready", reqReady, 1);
        checkOutput("mid reset resp_valid", respValid, 0);
        checkOutput("mid reset rdata", respRdata, 32'h0);
        checkOutput("mid reset err", respErr, 0);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(mk(1'b0, 32'h0000_0030, 32'h0, 4'h0, 0, 1'b0, 32'h0BAD_F00D, 1'b0), 1'b0);

        foreach (alignVecs[i]) begin
            applyStimulus(alignVecs[i], 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
